// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and oversampling ratio.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_ser.sv
// UART transmitter: shifts one parallel word out LSB first (start, DBIT data, stop),
// pacing each bit by OVERSAMPLE ticks of the 16x baud enable s_tick.
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx,
  output uart_tx_state_t  dbg_state_o
);

  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  // Handshake: tx_start is a level request, consumed only on an edge where the
  // FSM is IDLE; din is captured on that same edge. tx_busy is low exactly when
  // a request would be accepted. tx_done_tick marks the first IDLE cycle after STOP.

  uart_tx_state_t  state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          b_d     = din;
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            b_d = b_q >> 1;
            s_d = '0;
            if (n_q == N_LAST) state_d = STOP;
            else               n_d     = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line value follows the next state so tx toggles on the same edge as the FSM.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;
  assign tx_busy      = (state_q != IDLE);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_uart_tx_ser.sv
// Directed bench for uart_tx_ser (DBIT=8, SB_TICK=16): frame shape, pacing,
// handshake corner cases and mid-frame reset.
module tb_uart_tx_ser;
  import uart_pkg::*;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           s_tick = 1'b1;
  logic           tx_start = 1'b0;
  logic [7:0]     din = 8'h00;
  logic           tx_busy;
  logic           tx_done_tick;
  logic           tx;
  uart_tx_state_t dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_ser #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
    .din          (din),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .tx           (tx),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input string what, input int cyc,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s @%0d: observed %0h expected %0h", tag, what, cyc, obs, exp);
    end
  endtask

  // Called just after the accepting edge. Each frame bit lasts 16*p clocks,
  // s_tick being asserted before every p-th edge counted from acceptance.
  task automatic run_frame(input logic [7:0] d, input int p, input string tag,
                           input bit hold, input bit poke_din, input bit poke_start);
    logic [9:0] frame;
    int         bit_len;
    frame   = {1'b1, d, 1'b0};
    bit_len = 16 * p;
    if (!hold) tx_start = 1'b0;
    check(tag, "tx", 0, 32'(tx), 32'(frame[0]));
    check(tag, "busy", 0, 32'(tx_busy), 32'd1);
    check(tag, "done", 0, 32'(tx_done_tick), 32'd0);
    for (int e = 1; e <= 10 * bit_len; e++) begin
      s_tick = ((e % p) == 0);
      if (poke_din && e == 5 * bit_len) din = 8'h00;
      if (poke_start && e == 3 * bit_len + 7) begin
        tx_start = 1'b1;
        din      = ~d;
      end
      if (poke_start && e == 3 * bit_len + 8) begin
        tx_start = 1'b0;
        din      = d;
      end
      step();
      if (e < 10 * bit_len) begin
        check(tag, "tx", e, 32'(tx), 32'(frame[e / bit_len]));
        check(tag, "busy", e, 32'(tx_busy), 32'd1);
        check(tag, "done", e, 32'(tx_done_tick), 32'd0);
      end else begin
        check(tag, "done_end", e, 32'(tx_done_tick), 32'd1);
        check(tag, "busy_end", e, 32'(tx_busy), 32'd0);
        check(tag, "tx_end", e, 32'(tx), 32'd1);
      end
    end
  endtask

  initial begin
    // Reset held for 3 clocks with s_tick high.
    reset    = 1'b1;
    s_tick   = 1'b1;
    tx_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset", "tx", i, 32'(tx), 32'd1);
      check("reset", "busy", i, 32'(tx_busy), 32'd0);
      check("reset", "done", i, 32'(tx_done_tick), 32'd0);
      check("reset", "state", i, 32'(dbg_state), 32'(IDLE));
    end
    reset = 1'b0;
    step();
    check("idle", "tx", 0, 32'(tx), 32'd1);
    check("idle", "busy", 0, 32'(tx_busy), 32'd0);

    // 0xA5 at full tick rate: 160 clocks per frame.
    din      = 8'hA5;
    tx_start = 1'b1;
    step();
    run_frame(8'hA5, 1, "fast_a5", 1'b0, 1'b0, 1'b0);
    step();
    check("fast_a5", "done_single", 0, 32'(tx_done_tick), 32'd0);

    // 0xA5 with s_tick every 163 clocks; din cleared mid-frame must not matter.
    s_tick   = 1'b0;
    din      = 8'hA5;
    tx_start = 1'b1;
    step();
    run_frame(8'hA5, 163, "slow_a5", 1'b0, 1'b1, 1'b0);
    s_tick = 1'b1;
    step();
    check("slow_a5", "done_single", 0, 32'(tx_done_tick), 32'd0);

    // tx_start held: three back-to-back frames.
    din      = 8'h81;
    tx_start = 1'b1;
    step();
    run_frame(8'h81, 1, "b2b_0", 1'b1, 1'b0, 1'b0);
    din = 8'h3E;
    step();
    run_frame(8'h3E, 1, "b2b_1", 1'b1, 1'b0, 1'b0);
    din = 8'hF0;
    step();
    run_frame(8'hF0, 1, "b2b_2", 1'b0, 1'b0, 1'b0);
    step();
    check("b2b_2", "done_single", 0, 32'(tx_done_tick), 32'd0);
    check("b2b_2", "idle_after", 0, 32'(tx_busy), 32'd0);

    // Request pulsed during DATA is ignored.
    din      = 8'hC3;
    tx_start = 1'b1;
    step();
    run_frame(8'hC3, 1, "ignore_start", 1'b0, 1'b0, 1'b1);
    step();
    check("ignore_start", "no_requeue", 0, 32'(tx_busy), 32'd0);
    check("ignore_start", "done_single", 0, 32'(tx_done_tick), 32'd0);

    // Reset during data bit 3, then a clean 0x3C frame.
    din      = 8'h5A;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    for (int i = 0; i < 16 * 4 + 5; i++) step();
    check("mid_reset", "pre_state", 0, 32'(dbg_state), 32'(DATA));
    check("mid_reset", "pre_tx", 0, 32'(tx), 32'd1);  // 0x5A bit 3 is 1
    reset = 1'b1;
    step();
    check("mid_reset", "tx", 1, 32'(tx), 32'd1);
    check("mid_reset", "state", 1, 32'(dbg_state), 32'(IDLE));
    check("mid_reset", "busy", 1, 32'(tx_busy), 32'd0);
    check("mid_reset", "done", 1, 32'(tx_done_tick), 32'd0);
    reset = 1'b0;
    step();
    check("mid_reset", "done_after", 2, 32'(tx_done_tick), 32'd0);
    check("mid_reset", "tx_after", 2, 32'(tx), 32'd1);
    din      = 8'h3C;
    tx_start = 1'b1;
    step();
    run_frame(8'h3C, 1, "post_reset_3c", 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
